// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing source for the 640x480@60 display path. It runs from the
//   system clock and uses a pixel-rate enable instead of a derived clock. It
//   drives the DrawX/DrawY/blank/frame interface that the sprite and ROM
//   renderers sample, and it provides the per-frame tick that the motion
//   update logic uses as a clock enable.
//
//   Parameters
//     H_VISIBLE/H_FRONT/H_SYNC/H_BACK  horizontal timing, in pixels
//     V_VISIBLE/V_FRONT/V_SYNC/V_BACK  vertical timing, in lines
//     CLK_DIV                          Clk cycles per pixel, 1..4
//
//   Ports
//     Clk         in   system clock
//     Reset       in   synchronous, active-high reset
//     pixel_en    out  one-Clk pulse; counters advance on edges where it is 1
//     DrawX       out  current pixel column (10 bits)
//     DrawY       out  current line (10 bits)
//     blank       out  1 inside the visible region, 0 = drive black
//     hs          out  horizontal sync, active low
//     vs          out  vertical sync, active low
//     sync        out  composite sync, tied to 0
//     frame_tick  out  one-Clk pulse at the start of vertical blank
//     frame_cnt   out  16-bit frame counter
//
//   Build option
//     VGA_FRAME_COUNTER_EN  when defined, frame_cnt counts frame_tick pulses
//                           and wraps at 16 bits. When undefined, frame_cnt is
//                           a constant zero and no counter register exists.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        pixel_en,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        sync,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);

  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Two bits cover the legal divide range of 1..4.
  localparam logic [1:0] DIV_LAST   = 2'(CLK_DIV - 1);

  logic [1:0] div_q, div_d;
  logic [9:0] hc_q,  hc_d;
  logic [9:0] vc_q,  vc_d;

  logic       pix_en;
  logic       line_end;

  // With CLK_DIV=1, DIV_LAST is 0, so div never leaves 0 and pix_en stays high.
  assign pix_en   = (div_q == DIV_LAST);
  assign line_end = (hc_q == H_LAST);

  always_comb begin
    div_d = div_q;
    hc_d  = hc_q;
    vc_d  = vc_q;

    if (pix_en) begin
      div_d = '0;
    end else begin
      div_d = div_q + 2'd1;
    end

    if (pix_en) begin
      if (line_end) begin
        hc_d = '0;
        if (vc_q == V_LAST) begin
          vc_d = '0;
        end else begin
          vc_d = vc_q + 10'd1;
        end
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
    end else begin
      div_q <= div_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
    end
  end

  // Every decode below comes directly from the counter registers. This keeps
  // the syncs and blank in the same cycle as DrawX/DrawY.
  always_comb begin
    pixel_en   = pix_en;
    DrawX      = hc_q;
    DrawY      = vc_q;
    blank      = (hc_q < H_VIS_END) && (vc_q < V_VIS_END);
    hs         = !((hc_q >= HS_START) && (hc_q < HS_END));
    vs         = !((vc_q >= VS_START) && (vc_q < VS_END));
    sync       = 1'b0;
    // The tick fires on the edge that moves DrawY onto the first blank line.
    frame_tick = pix_en && line_end && (vc_q == V_VIS_LAST);
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_tick) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef VGA_FRAME_COUNTER_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Instance A: default timing, CLK_DIV=2.
  logic rst_a = 1'b1;
  logic pen_a, blank_a, hs_a, vs_a, sync_a, ft_a;
  logic [9:0] x_a, y_a;
  logic [15:0] fc_a;
  vga_timing_gen u_a (
    .Clk(clk), .Reset(rst_a), .pixel_en(pen_a), .DrawX(x_a), .DrawY(y_a),
    .blank(blank_a), .hs(hs_a), .vs(vs_a), .sync(sync_a),
    .frame_tick(ft_a), .frame_cnt(fc_a));

  // Instance B: small timing (16x12 total), CLK_DIV=2.
  logic rst_b = 1'b1;
  logic pen_b, blank_b, hs_b, vs_b, sync_b, ft_b;
  logic [9:0] x_b, y_b;
  logic [15:0] fc_b;
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .CLK_DIV(2)
  ) u_b (
    .Clk(clk), .Reset(rst_b), .pixel_en(pen_b), .DrawX(x_b), .DrawY(y_b),
    .blank(blank_b), .hs(hs_b), .vs(vs_b), .sync(sync_b),
    .frame_tick(ft_b), .frame_cnt(fc_b));

  // Instance C: default timing, CLK_DIV=1.
  logic rst_c = 1'b1;
  logic pen_c, blank_c, hs_c, vs_c, sync_c, ft_c;
  logic [9:0] x_c, y_c;
  logic [15:0] fc_c;
  vga_timing_gen #(.CLK_DIV(1)) u_c (
    .Clk(clk), .Reset(rst_c), .pixel_en(pen_c), .DrawX(x_c), .DrawY(y_c),
    .blank(blank_c), .hs(hs_c), .vs(vs_c), .sync(sync_c),
    .frame_tick(ft_c), .frame_cnt(fc_c));

  // Instance D: small timing, CLK_DIV=1.
  logic rst_d = 1'b1;
  logic pen_d, blank_d, hs_d, vs_d, sync_d, ft_d;
  logic [9:0] x_d, y_d;
  logic [15:0] fc_d;
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .CLK_DIV(1)
  ) u_d (
    .Clk(clk), .Reset(rst_d), .pixel_en(pen_d), .DrawX(x_d), .DrawY(y_d),
    .blank(blank_d), .hs(hs_d), .vs(vs_d), .sync(sync_d),
    .frame_tick(ft_d), .frame_cnt(fc_d));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance instance A by exactly one pixel.
  task automatic step_a();
    int guard;
    guard = 0;
    while (pen_a !== 1'b1 && guard < 8) begin
      tick(1);
      guard++;
    end
    checks++;
    if (pen_a !== 1'b1) begin
      failures++;
      $display("FAIL step_a_pixel_en got=%b want=1", pen_a);
    end
    tick(1);
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    tick(3);
    rst_a = 1'b0;
    checks += 8;
    if (x_a !== 10'd0)    begin failures++; $display("FAIL rst_drawx got=%0d want=0", x_a); end
    if (y_a !== 10'd0)    begin failures++; $display("FAIL rst_drawy got=%0d want=0", y_a); end
    if (blank_a !== 1'b1) begin failures++; $display("FAIL rst_blank got=%b want=1", blank_a); end
    if (hs_a !== 1'b1)    begin failures++; $display("FAIL rst_hs got=%b want=1", hs_a); end
    if (vs_a !== 1'b1)    begin failures++; $display("FAIL rst_vs got=%b want=1", vs_a); end
    if (ft_a !== 1'b0)    begin failures++; $display("FAIL rst_ftick got=%b want=0", ft_a); end
    if (sync_a !== 1'b0)  begin failures++; $display("FAIL rst_sync got=%b want=0", sync_a); end
    if (fc_a !== 16'd0)   begin failures++; $display("FAIL rst_fcnt got=%0d want=0", fc_a); end
    checks++;
    if (pen_a !== 1'b0) begin failures++; $display("FAIL rst_pen0 got=%b want=0", pen_a); end
    tick(1);
    checks += 2;
    if (pen_a !== 1'b1) begin failures++; $display("FAIL first_pen got=%b want=1", pen_a); end
    if (x_a !== 10'd0)  begin failures++; $display("FAIL first_pen_x got=%0d want=0", x_a); end
    tick(1);
    checks += 2;
    if (x_a !== 10'd1)  begin failures++; $display("FAIL first_adv_x got=%0d want=1", x_a); end
    if (pen_a !== 1'b0) begin failures++; $display("FAIL first_adv_pen got=%b want=0", pen_a); end
  endtask

  task automatic test_hsync();
    int low_cnt, first_low, first_high;
    logic exp_hs, exp_blank;
    low_cnt = 0; first_low = -1; first_high = -1;
    for (int x = 2; x < 800; x++) begin
      step_a();
      exp_hs    = !(x >= 656 && x < 752);
      exp_blank = (x < 640);
      checks += 3;
      if (x_a !== 10'(x))       begin failures++; $display("FAIL hs_drawx got=%0d want=%0d", x_a, x); end
      if (hs_a !== exp_hs)      begin failures++; $display("FAIL hs_level x=%0d got=%b want=%b", x, hs_a, exp_hs); end
      if (blank_a !== exp_blank) begin failures++; $display("FAIL hs_blank x=%0d got=%b want=%b", x, blank_a, exp_blank); end
      if (hs_a === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = x;
      end else if (first_low >= 0 && first_high < 0) begin
        first_high = x;
      end
    end
    checks += 3;
    if (low_cnt !== 96)    begin failures++; $display("FAIL hs_width got=%0d want=96", low_cnt); end
    if (first_low !== 656) begin failures++; $display("FAIL hs_fall got=%0d want=656", first_low); end
    if (first_high !== 752) begin failures++; $display("FAIL hs_rise got=%0d want=752", first_high); end
    step_a();
    checks += 3;
    if (x_a !== 10'd0)    begin failures++; $display("FAIL line0_wrap_x got=%0d want=0", x_a); end
    if (y_a !== 10'd1)    begin failures++; $display("FAIL line0_wrap_y got=%0d want=1", y_a); end
    if (blank_a !== 1'b1) begin failures++; $display("FAIL line0_wrap_blank got=%b want=1", blank_a); end
  endtask

  task automatic test_line_wrap();
    int guard;
    guard = 0;
    while (!(x_a == 10'd799 && y_a == 10'd10) && guard < 10000) begin
      step_a();
      guard++;
    end
    checks += 3;
    if (x_a !== 10'd799)  begin failures++; $display("FAIL lw_reach_x got=%0d want=799", x_a); end
    if (y_a !== 10'd10)   begin failures++; $display("FAIL lw_reach_y got=%0d want=10", y_a); end
    if (blank_a !== 1'b0) begin failures++; $display("FAIL lw_blank_799 got=%b want=0", blank_a); end
    guard = 0;
    while (pen_a !== 1'b1 && guard < 8) begin
      tick(1);
      guard++;
    end
    checks++;
    if (ft_a !== 1'b0) begin failures++; $display("FAIL lw_no_ftick got=%b want=0", ft_a); end
    step_a();
    checks += 3;
    if (x_a !== 10'd0)    begin failures++; $display("FAIL lw_x got=%0d want=0", x_a); end
    if (y_a !== 10'd11)   begin failures++; $display("FAIL lw_y got=%0d want=11", y_a); end
    if (blank_a !== 1'b1) begin failures++; $display("FAIL lw_blank got=%b want=1", blank_a); end
  endtask

  // Small timing: hs low for DrawX 10..12, vs low for DrawY 8..9, frame = 192 pixels.
  task automatic test_frame();
    int n_ticks, t0, t1, vs_low, vs_bad;
    logic exp_vs;
    n_ticks = 0; t0 = -1; t1 = -1; vs_low = 0; vs_bad = 0;
    rst_b = 1'b1;
    tick(2);
    rst_b = 1'b0;
    checks += 3;
    if (blank_b !== 1'b1) begin failures++; $display("FAIL fr_rst_blank got=%b want=1", blank_b); end
    if (sync_b !== 1'b0)  begin failures++; $display("FAIL fr_rst_sync got=%b want=0", sync_b); end
    if (hs_b !== 1'b1)    begin failures++; $display("FAIL fr_rst_hs got=%b want=1", hs_b); end
    for (int k = 0; k < 800; k++) begin
      exp_vs = !(y_b >= 10'd8 && y_b < 10'd10);
      if (vs_b !== exp_vs) vs_bad++;
      if (vs_b === 1'b0) vs_low++;
      if (ft_b === 1'b1) begin
        if (n_ticks == 0) t0 = k;
        if (n_ticks == 1) t1 = k;
        n_ticks++;
        checks += 3;
        if (x_b !== 10'd15) begin failures++; $display("FAIL fr_tick_x got=%0d want=15", x_b); end
        if (y_b !== 10'd5)  begin failures++; $display("FAIL fr_tick_y got=%0d want=5", y_b); end
        if (pen_b !== 1'b1) begin failures++; $display("FAIL fr_tick_pen got=%b want=1", pen_b); end
      end
      if (k == 191) begin
        checks++;
        if (fc_b !== 16'd0) begin failures++; $display("FAIL fr_fcnt0 got=%0d want=0", fc_b); end
      end
      if (k == 192) begin
        checks += 2;
        if (y_b !== 10'd6) begin failures++; $display("FAIL fr_vblank_y got=%0d want=6", y_b); end
        if (fc_b !== (FC_EN ? 16'd1 : 16'd0)) begin
          failures++; $display("FAIL fr_fcnt1 got=%0d want=%0d", fc_b, FC_EN ? 1 : 0);
        end
      end
      if (k == 383) begin
        checks += 2;
        if (x_b !== 10'd15 || y_b !== 10'd11) begin
          failures++; $display("FAIL fr_last_px got=%0d,%0d want=15,11", x_b, y_b);
        end
        if (pen_b !== 1'b1) begin failures++; $display("FAIL fr_last_pen got=%b want=1", pen_b); end
      end
      if (k == 384) begin
        checks++;
        if (x_b !== 10'd0 || y_b !== 10'd0) begin
          failures++; $display("FAIL fr_wrap got=%0d,%0d want=0,0", x_b, y_b);
        end
      end
      if (k == 576) begin
        checks++;
        if (fc_b !== (FC_EN ? 16'd2 : 16'd0)) begin
          failures++; $display("FAIL fr_fcnt2 got=%0d want=%0d", fc_b, FC_EN ? 2 : 0);
        end
      end
      tick(1);
    end
    checks += 5;
    if (n_ticks !== 2) begin failures++; $display("FAIL fr_tick_count got=%0d want=2", n_ticks); end
    if (t0 !== 191)    begin failures++; $display("FAIL fr_tick0_at got=%0d want=191", t0); end
    if (t1 !== 575)    begin failures++; $display("FAIL fr_tick1_at got=%0d want=575", t1); end
    if (vs_bad !== 0)  begin failures++; $display("FAIL fr_vs_decode got=%0d want=0", vs_bad); end
    if (vs_low !== 128) begin failures++; $display("FAIL fr_vs_low got=%0d want=128", vs_low); end
  endtask

  // Reset lands on a pixel_en edge inside both sync pulses.
  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (!(x_b == 10'd11 && y_b == 10'd9 && pen_b === 1'b1) && guard < 500) begin
      tick(1);
      guard++;
    end
    checks += 3;
    if (x_b !== 10'd11 || y_b !== 10'd9) begin
      failures++; $display("FAIL rm_reach got=%0d,%0d want=11,9", x_b, y_b);
    end
    if (hs_b !== 1'b0) begin failures++; $display("FAIL rm_pre_hs got=%b want=0", hs_b); end
    if (vs_b !== 1'b0) begin failures++; $display("FAIL rm_pre_vs got=%b want=0", vs_b); end
    rst_b = 1'b1;
    tick(1);
    rst_b = 1'b0;
    checks += 8;
    if (x_b !== 10'd0)    begin failures++; $display("FAIL rm_x got=%0d want=0", x_b); end
    if (y_b !== 10'd0)    begin failures++; $display("FAIL rm_y got=%0d want=0", y_b); end
    if (hs_b !== 1'b1)    begin failures++; $display("FAIL rm_hs got=%b want=1", hs_b); end
    if (vs_b !== 1'b1)    begin failures++; $display("FAIL rm_vs got=%b want=1", vs_b); end
    if (blank_b !== 1'b1) begin failures++; $display("FAIL rm_blank got=%b want=1", blank_b); end
    if (ft_b !== 1'b0)    begin failures++; $display("FAIL rm_ftick got=%b want=0", ft_b); end
    if (pen_b !== 1'b0)   begin failures++; $display("FAIL rm_pen got=%b want=0", pen_b); end
    if (fc_b !== 16'd0)   begin failures++; $display("FAIL rm_fcnt got=%0d want=0", fc_b); end
  endtask

  task automatic test_clkdiv1();
    int pen_bad, hs_bad, x_bad, blank_bad, vs_bad, low_cnt;
    logic exp_hs;
    pen_bad = 0; hs_bad = 0; x_bad = 0; blank_bad = 0; vs_bad = 0; low_cnt = 0;
    rst_c = 1'b1;
    tick(2);
    rst_c = 1'b0;
    for (int k = 0; k < 800; k++) begin
      exp_hs = !(k >= 656 && k < 752);
      if (pen_c !== 1'b1) pen_bad++;
      if (x_c !== 10'(k) || y_c !== 10'd0) x_bad++;
      if (hs_c !== exp_hs) hs_bad++;
      if (blank_c !== (k < 640)) blank_bad++;
      if (vs_c !== 1'b1 || ft_c !== 1'b0 || sync_c !== 1'b0) vs_bad++;
      if (hs_c === 1'b0) low_cnt++;
      tick(1);
    end
    checks += 8;
    if (pen_bad !== 0)   begin failures++; $display("FAIL d1_pen got=%0d want=0", pen_bad); end
    if (x_bad !== 0)     begin failures++; $display("FAIL d1_drawx got=%0d want=0", x_bad); end
    if (hs_bad !== 0)    begin failures++; $display("FAIL d1_hs got=%0d want=0", hs_bad); end
    if (blank_bad !== 0) begin failures++; $display("FAIL d1_blank got=%0d want=0", blank_bad); end
    if (vs_bad !== 0)    begin failures++; $display("FAIL d1_vs_ft got=%0d want=0", vs_bad); end
    if (low_cnt !== 96)  begin failures++; $display("FAIL d1_hs_width got=%0d want=96", low_cnt); end
    if (x_c !== 10'd0)   begin failures++; $display("FAIL d1_line_x got=%0d want=0", x_c); end
    if (y_c !== 10'd1)   begin failures++; $display("FAIL d1_line_y got=%0d want=1", y_c); end
    checks++;
    if (fc_c !== 16'd0)  begin failures++; $display("FAIL d1_fcnt got=%0d want=0", fc_c); end
  endtask

  task automatic test_frame_div1();
    int n_ticks, t0, t1, guard;
    n_ticks = 0; t0 = -1; t1 = -1;
    rst_d = 1'b1;
    tick(2);
    rst_d = 1'b0;
    checks += 4;
    if (hs_d !== 1'b1)    begin failures++; $display("FAIL f1_rst_hs got=%b want=1", hs_d); end
    if (vs_d !== 1'b1)    begin failures++; $display("FAIL f1_rst_vs got=%b want=1", vs_d); end
    if (blank_d !== 1'b1) begin failures++; $display("FAIL f1_rst_blank got=%b want=1", blank_d); end
    if (sync_d !== 1'b0)  begin failures++; $display("FAIL f1_rst_sync got=%b want=0", sync_d); end
    for (int k = 0; k < 400; k++) begin
      if (ft_d === 1'b1) begin
        if (n_ticks == 0) t0 = k;
        if (n_ticks == 1) t1 = k;
        n_ticks++;
      end
      if (k == 96) begin
        checks++;
        if (fc_d !== (FC_EN ? 16'd1 : 16'd0)) begin
          failures++; $display("FAIL f1_fcnt1 got=%0d want=%0d", fc_d, FC_EN ? 1 : 0);
        end
      end
      if (k == 192) begin
        checks++;
        if (x_d !== 10'd0 || y_d !== 10'd0) begin
          failures++; $display("FAIL f1_wrap got=%0d,%0d want=0,0", x_d, y_d);
        end
      end
      if (k == 288) begin
        checks++;
        if (fc_d !== (FC_EN ? 16'd2 : 16'd0)) begin
          failures++; $display("FAIL f1_fcnt2 got=%0d want=%0d", fc_d, FC_EN ? 2 : 0);
        end
      end
      tick(1);
    end
    checks += 3;
    if (n_ticks !== 2) begin failures++; $display("FAIL f1_tick_count got=%0d want=2", n_ticks); end
    if (t0 !== 95)     begin failures++; $display("FAIL f1_tick0_at got=%0d want=95", t0); end
    if (t1 !== 287)    begin failures++; $display("FAIL f1_tick1_at got=%0d want=287", t1); end
    // Reset asserted on the very edge that would otherwise move into vertical blank.
    guard = 0;
    while (ft_d !== 1'b1 && guard < 300) begin
      tick(1);
      guard++;
    end
    checks++;
    if (ft_d !== 1'b1) begin failures++; $display("FAIL f1_tick_wait got=%b want=1", ft_d); end
    rst_d = 1'b1;
    tick(1);
    rst_d = 1'b0;
    checks += 4;
    if (x_d !== 10'd0)  begin failures++; $display("FAIL f1_rp_x got=%0d want=0", x_d); end
    if (y_d !== 10'd0)  begin failures++; $display("FAIL f1_rp_y got=%0d want=0", y_d); end
    if (ft_d !== 1'b0)  begin failures++; $display("FAIL f1_rp_ftick got=%b want=0", ft_d); end
    if (fc_d !== 16'd0) begin failures++; $display("FAIL f1_rp_fcnt got=%0d want=0", fc_d); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(1);
    test_reset();
    test_hsync();
    test_line_wrap();
    test_frame();
    test_reset_mid();
    test_clkdiv1();
    test_frame_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
